// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM state encoding and byte-strobe constants.
package dmem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] STRB_WORD    = 4'b1111;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_BYTE0   = 4'b0001;

endpackage

// File: rtl/dmem_strobe_gen.sv
// Combinational decode of store size and address low bits into bus strobes, lane-replicated data,
// write flag and misalignment. Priority is word > half > byte; anything else is a read.
module dmem_strobe_gen
    import dmem_bus_bridge_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic        i_byte_en,
    input  logic        i_half_en,
    input  logic        i_word_en,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_we,
    output logic        o_misalign
);

    always_comb begin
        o_wstrb    = 4'b0000;
        o_wdata    = 32'h0;
        o_we       = 1'b0;
        o_misalign = 1'b0;
        if (i_word_en) begin
            o_wstrb    = STRB_WORD;
            o_wdata    = i_wdata;
            o_we       = 1'b1;
            o_misalign = (i_addr_lo != 2'b00);
        end else if (i_half_en) begin
            o_wstrb    = i_addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
            o_wdata    = {2{i_wdata[15:0]}};
            o_we       = 1'b1;
            o_misalign = i_addr_lo[0];
        end else if (i_byte_en) begin
            o_wstrb    = STRB_BYTE0 << i_addr_lo;
            o_wdata    = {4{i_wdata[7:0]}};
            o_we       = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the memory stage to a wait-stated valid/ready bus, stalling the pipeline until completion.
// Optional REQ timeout with bus_error output is enabled by defining DMEM_BUS_BRIDGE_TIMEOUT_EN.
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic              write_byte_en,
    input  logic              write_half_en,
    input  logic              write_word_en,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              misalign,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [DATA_W-1:0] bus_rdata
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
    ,
    output logic              bus_error
`endif
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("dmem_bus_bridge: DATA_W must be 32");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("dmem_bus_bridge: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    state_t            r_state;
    logic              r_bus_valid;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [3:0]        r_bus_wstrb;
    logic [DATA_W-1:0] r_read_data;
    logic              r_misalign;

    logic              w_req;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic              w_misalign;

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
    localparam int TO_CLOG = $clog2(TIMEOUT_CYC + 1);
    localparam int TO_W    = (TO_CLOG > 8) ? TO_CLOG : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0]   r_cnt;
    logic              r_bus_error;
    assign bus_error = r_bus_error;
`endif

    assign w_req = read_en | write_byte_en | write_half_en | write_word_en;

    dmem_strobe_gen u_strobe_gen (
        .i_addr_lo  (addr[1:0]),
        .i_byte_en  (write_byte_en),
        .i_half_en  (write_half_en),
        .i_word_en  (write_word_en),
        .i_wdata    (write_data),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_we       (w_we),
        .o_misalign (w_misalign)
    );

    // The pipeline is released in DONE, so each access advances it exactly once.
    assign stall     = ((r_state == ST_IDLE) && w_req) || (r_state == ST_REQ);
    assign bus_valid = r_bus_valid;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wstrb = r_bus_wstrb;
    assign read_data = r_read_data;
    assign misalign  = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= 4'b0000;
            r_read_data <= '0;
            r_misalign  <= 1'b0;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
            r_cnt       <= '0;
            r_bus_error <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_bus_valid <= 1'b1;
                            r_bus_we    <= w_we;
                            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_bus_wdata <= w_wdata;
                            r_bus_wstrb <= w_wstrb;
                            r_state     <= ST_REQ;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
                            r_cnt       <= '0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ready) begin
                        r_bus_valid <= 1'b0;
                        if (!r_bus_we) begin
                            r_read_data <= bus_rdata;
                        end
                        r_state <= ST_DONE;
                    end
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_bus_valid <= 1'b0;
                        r_read_data <= '0;
                        r_bus_error <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_misalign <= 1'b0;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
                    r_bus_error <= 1'b0;
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge; timeout checks run only when DMEM_BUS_BRIDGE_TIMEOUT_EN is defined.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        read_en, write_byte_en, write_half_en, write_word_en;
    logic [31:0] read_data;
    logic        stall, misalign, bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
    logic        bus_error;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_vcyc = 0;
    int snap;

    always #5 clk = ~clk;

    dmem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .write_data    (write_data),
        .read_en       (read_en),
        .write_byte_en (write_byte_en),
        .write_half_en (write_half_en),
        .write_word_en (write_word_en),
        .read_data     (read_data),
        .stall         (stall),
        .misalign      (misalign),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_rdata     (bus_rdata)
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
        ,
        .bus_error     (bus_error)
`endif
    );

    always @(posedge clk) begin
        if (bus_valid) n_vcyc <= n_vcyc + 1;
        if (bus_valid && bus_ready && bus_we) n_wr <= n_wr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        read_en = 0; write_byte_en = 0; write_half_en = 0; write_word_en = 0;
        bus_ready = 0;
    endtask

    initial begin
        rst = 1; addr = 0; write_data = 0; bus_rdata = 0;
        idle_inputs();
        tick(); tick();
        #1;
        chk1("rst_valid", bus_valid, 1'b0);
        chk1("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        tick();
        rst = 0;
        tick();

        // Byte store, zero-wait bus
        addr = 32'h103; write_data = 32'h0000_00AB; write_byte_en = 1;
        #1 chk1("b_idle_stall", stall, 1'b1);
        chk1("b_idle_valid", bus_valid, 1'b0);
        tick();
        chk1("b_req_valid", bus_valid, 1'b1);
        chk("b_req_wstrb", {28'h0, bus_wstrb}, 32'h8);
        chk("b_req_wdata", bus_wdata, 32'hABAB_ABAB);
        chk("b_req_addr", bus_addr, 32'h100);
        chk1("b_req_we", bus_we, 1'b1);
        bus_ready = 1;
        #1 chk1("b_req_stall", stall, 1'b1);
        tick();
        chk1("b_done_stall", stall, 1'b0);
        chk1("b_done_valid", bus_valid, 1'b0);
        idle_inputs();
        tick();
        chk1("b_idle2_stall", stall, 1'b0);

        // Word load with three wait cycles
        addr = 32'h200; read_en = 1;
        #1 chk1("l_idle_stall", stall, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("l_wait_stall", stall, 1'b1);
            chk1("l_wait_valid", bus_valid, 1'b1);
            chk("l_wait_addr", bus_addr, 32'h200);
            chk("l_wait_wstrb", {28'h0, bus_wstrb}, 32'h0);
            chk1("l_wait_we", bus_we, 1'b0);
            tick();
        end
        bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
        #1 chk1("l_req_stall", stall, 1'b1);
        chk("l_req_addr", bus_addr, 32'h200);
        tick();
        chk1("l_done_stall", stall, 1'b0);
        chk("l_done_rdata", read_data, 32'hDEAD_BEEF);
        idle_inputs(); bus_rdata = 32'h0;
        tick();

        // Half store upper half, then misaligned half
        addr = 32'h202; write_data = 32'h0000_1234; write_half_en = 1;
        tick();
        chk("h_wstrb", {28'h0, bus_wstrb}, 32'hC);
        chk("h_wdata", bus_wdata, 32'h1234_1234);
        chk("h_addr", bus_addr, 32'h200);
        bus_ready = 1;
        tick();
        idle_inputs();
        tick();
        snap = n_vcyc;
        addr = 32'h201; write_half_en = 1;
        #1 chk1("m_idle_stall", stall, 1'b1);
        tick();
        chk1("m_done_misalign", misalign, 1'b1);
        chk1("m_done_valid", bus_valid, 1'b0);
        chk1("m_done_stall", stall, 1'b0);
        chk("m_done_rdata", read_data, 32'hDEAD_BEEF);
        idle_inputs();
        tick();
        chk1("m_idle_misalign", misalign, 1'b0);
        chk("m_no_valid", n_vcyc, snap);

        // Two identical-address word stores back to back
        addr = 32'h300; write_data = 32'h1; write_word_en = 1;
        tick();
        chk("w1_wdata", bus_wdata, 32'h1);
        chk("w1_wstrb", {28'h0, bus_wstrb}, 32'hF);
        bus_ready = 1;
        tick();
        chk1("w1_done_stall", stall, 1'b0);
        write_data = 32'h2;
        tick();
        chk1("w2_idle_valid", bus_valid, 1'b0);
        chk1("w2_idle_stall", stall, 1'b1);
        bus_ready = 0;
        tick();
        chk1("w2_req_valid", bus_valid, 1'b1);
        chk("w2_wdata", bus_wdata, 32'h2);
        chk("w2_addr", bus_addr, 32'h300);
        bus_ready = 1;
        tick();
        idle_inputs();
        tick();
        chk("write_count", n_wr, 4);

        // Reset in REQ, then a fresh load
        addr = 32'h400; read_en = 1;
        tick();
        chk1("r_req_valid", bus_valid, 1'b1);
        rst = 1; read_en = 0;
        #1 chk1("r_rst_valid", bus_valid, 1'b0);
        chk1("r_rst_stall", stall, 1'b0);
        tick();
        rst = 0;
        tick();
        addr = 32'h404; read_en = 1; bus_rdata = 32'h1357_9BDF;
        tick();
        chk("r2_addr", bus_addr, 32'h404);
        bus_ready = 1;
        tick();
        chk("r2_rdata", read_data, 32'h1357_9BDF);
        chk1("r2_stall", stall, 1'b0);
        idle_inputs();
        tick();

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
        // Timeout after four REQ cycles without bus_ready
        addr = 32'h500; read_en = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk1("t_req_stall", stall, 1'b1);
            chk1("t_req_err", bus_error, 1'b0);
            chk1("t_req_valid", bus_valid, 1'b1);
            tick();
        end
        chk1("t_done_err", bus_error, 1'b1);
        chk("t_done_rdata", read_data, 32'h0);
        chk1("t_done_stall", stall, 1'b0);
        chk1("t_done_valid", bus_valid, 1'b0);
        idle_inputs();
        tick();
        chk1("t_idle_err", bus_error, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
